// File: rtl/load_store_unit.sv
// MEM-stage load/store initiator: turns one load/store into a single word-aligned
// bus transaction, extends returned load data, and stalls the pipeline until done.
module load_store_unit #(
   parameter int XLEN           = 32,
   parameter int ALEN           = 32,
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            req_valid,
   input  logic            mem_read,
   input  logic            mem_write,
   input  logic [2:0]      funct3,
   input  logic [ALEN-1:0] addr,
   input  logic [XLEN-1:0] wdata,
   output logic            stall,
   output logic [XLEN-1:0] rdata,
   output logic            done,
   output logic            fault,
   output logic [1:0]      fault_cause,
   output logic            bus_req,
   output logic            bus_we,
   output logic [ALEN-1:0] bus_addr,
   output logic [3:0]      bus_be,
   output logic [31:0]     bus_wdata,
   input  logic            bus_gnt,
   input  logic            bus_rvalid,
   input  logic [31:0]     bus_rdata
);

   // state | meaning
   // IDLE  | decode/check incoming access, reject faults in the same cycle
   // REQ   | bus_req high with latched fields, waiting for bus_gnt
   // WAIT  | load granted, waiting for bus_rvalid
   // DONE  | one-cycle completion (done) or timeout (fault, cause 11)
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2,
      S_DONE = 2'd3
   } state_t;

   localparam int CW = $clog2(TIMEOUT_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

   localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
   localparam logic [1:0] CAUSE_ILLEGAL  = 2'b10;
   localparam logic [1:0] CAUSE_TIMEOUT  = 2'b11;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            we_q, we_d;
   logic [2:0]      f3_q, f3_d;
   logic [1:0]      off_q, off_d;
   logic [ALEN-1:0] addr_q, addr_d;
   logic [3:0]      be_q, be_d;
   logic [31:0]     wdata_q, wdata_d;
   logic [XLEN-1:0] rdata_q, rdata_d;
   logic            timeout_q, timeout_d;

   logic            access;
   logic            illegal;
   logic            misaligned;
   logic [3:0]      be_new;
   logic [31:0]     wdata_new;
   logic [7:0]      byte_sel;
   logic [15:0]     half_sel;
   logic [XLEN-1:0] load_ext;
   logic            cnt_expired;

   assign access = req_valid & (mem_read | mem_write);

   always_comb begin
      illegal = 1'b0;
      if (mem_read & mem_write)
         illegal = 1'b1;
      else if (mem_write && (funct3 != 3'b000) && (funct3 != 3'b001) && (funct3 != 3'b010))
         illegal = 1'b1;
      else if (mem_read && ((funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111)))
         illegal = 1'b1;
   end

   always_comb begin
      misaligned = 1'b0;
      if ((funct3[1:0] == 2'b01) && addr[0])
         misaligned = 1'b1;
      else if ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00))
         misaligned = 1'b1;
   end

   always_comb begin
      be_new    = 4'b1111;
      wdata_new = wdata[31:0];
      case (funct3[1:0])
         2'b00: begin
            be_new    = 4'b0001 << addr[1:0];
            wdata_new = {4{wdata[7:0]}};
         end
         2'b01: begin
            be_new    = 4'b0011 << addr[1:0];
            wdata_new = {2{wdata[15:0]}};
         end
         default: begin
            be_new    = 4'b1111;
            wdata_new = wdata[31:0];
         end
      endcase
   end

   // Lane extraction uses the offset latched at accept time, not the live address.
   assign byte_sel = 8'(bus_rdata >> {off_q, 3'b000});
   assign half_sel = off_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];

   always_comb begin
      case (f3_q)
         3'b000:  load_ext = XLEN'($signed(byte_sel));
         3'b100:  load_ext = XLEN'(byte_sel);
         3'b001:  load_ext = XLEN'($signed(half_sel));
         3'b101:  load_ext = XLEN'(half_sel);
         default: load_ext = XLEN'($signed(bus_rdata));
      endcase
   end

   assign cnt_expired = (cnt_q == CNT_LAST);

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      we_d        = we_q;
      f3_d        = f3_q;
      off_d       = off_q;
      addr_d      = addr_q;
      be_d        = be_q;
      wdata_d     = wdata_q;
      rdata_d     = rdata_q;
      timeout_d   = timeout_q;
      stall       = 1'b0;
      done        = 1'b0;
      fault       = 1'b0;
      fault_cause = 2'b00;
      bus_req     = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (access) begin
               if (illegal) begin
                  fault       = 1'b1;
                  fault_cause = CAUSE_ILLEGAL;
               end else if (misaligned) begin
                  fault       = 1'b1;
                  fault_cause = CAUSE_MISALIGN;
               end else begin
                  stall     = 1'b1;
                  we_d      = mem_write;
                  f3_d      = funct3;
                  off_d     = addr[1:0];
                  addr_d    = {addr[ALEN-1:2], 2'b00};
                  be_d      = be_new;
                  wdata_d   = wdata_new;
                  cnt_d     = '0;
                  timeout_d = 1'b0;
                  state_d   = S_REQ;
               end
            end
         end

         S_REQ: begin
            bus_req = 1'b1;
            stall   = 1'b1;
            cnt_d   = cnt_q + CW'(1);
            if (bus_gnt) begin
               state_d = we_q ? S_DONE : S_WAIT;
            end else if (cnt_expired) begin
               timeout_d = 1'b1;
               state_d   = S_DONE;
            end
         end

         S_WAIT: begin
            stall = 1'b1;
            cnt_d = cnt_q + CW'(1);
            if (bus_rvalid) begin
               rdata_d = load_ext;
               state_d = S_DONE;
            end else if (cnt_expired) begin
               timeout_d = 1'b1;
               state_d   = S_DONE;
            end
         end

         S_DONE: begin
            done        = ~timeout_q;
            fault       = timeout_q;
            fault_cause = timeout_q ? CAUSE_TIMEOUT : 2'b00;
            timeout_d   = 1'b0;
            state_d     = S_IDLE;
         end

         default: state_d = S_IDLE;
      endcase
   end

   // Stores and timeouts report zero in DONE; otherwise the last load result is held.
   assign rdata     = ((state_q == S_DONE) && (we_q || timeout_q)) ? '0 : rdata_q;
   assign bus_we    = bus_req & we_q;
   assign bus_addr  = bus_req ? addr_q : '0;
   assign bus_be    = bus_req ? be_q : 4'b0000;
   assign bus_wdata = bus_req ? wdata_q : 32'h0;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         we_q      <= 1'b0;
         f3_q      <= 3'b000;
         off_q     <= 2'b00;
         addr_q    <= '0;
         be_q      <= 4'b0000;
         wdata_q   <= 32'h0;
         rdata_q   <= '0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         we_q      <= we_d;
         f3_q      <= f3_d;
         off_q     <= off_d;
         addr_q    <= addr_d;
         be_q      <= be_d;
         wdata_q   <= wdata_d;
         rdata_q   <= rdata_d;
         timeout_q <= timeout_d;
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed scenarios plus random accesses checked
// against an arithmetic model of byte lanes, extension and completion timing.
module tb_load_store_unit;

   localparam int T = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, mem_read, mem_write;
   logic [2:0]  funct3;
   logic [31:0] addr, wdata;
   logic        stall, done, fault;
   logic [31:0] rdata;
   logic [1:0]  fault_cause;
   logic        bus_req, bus_we;
   logic [31:0] bus_addr;
   logic [3:0]  bus_be;
   logic [31:0] bus_wdata;
   logic        bus_gnt, bus_rvalid;
   logic [31:0] bus_rdata;

   int n_tests = 0;
   int n_fail  = 0;
   logic [31:0] m_rdata = 32'h0;

   load_store_unit #(.XLEN(32), .ALEN(32), .TIMEOUT_CYCLES(T)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .mem_read(mem_read),
      .mem_write(mem_write), .funct3(funct3), .addr(addr), .wdata(wdata),
      .stall(stall), .rdata(rdata), .done(done), .fault(fault),
      .fault_cause(fault_cause), .bus_req(bus_req), .bus_we(bus_we),
      .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata),
      .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic idle_inputs();
      req_valid = 0; mem_read = 0; mem_write = 0; funct3 = 0; addr = 0; wdata = 0;
      bus_gnt = 0; bus_rvalid = 0;
   endtask

   function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a,
                                              input logic [31:0] word);
      longint unsigned v;
      v = longint'(word) >> (8 * (a % 4));
      case (f3)
         3'd0: begin v = v % 256;   if (v >= 128)   v = v + 64'hFFFFFF00; end
         3'd4: v = v % 256;
         3'd1: begin v = v % 65536; if (v >= 32768) v = v + 64'hFFFF0000; end
         3'd5: v = v % 65536;
         default: v = longint'(word);
      endcase
      return v[31:0];
   endfunction

   // Entered and left just after a rising edge. g = gnt cycle (index from first
   // REQ cycle), r = rvalid delay after gnt.
   task automatic run_access(input string tag, input bit rd, input bit wr,
                             input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] wd, input int g, input int r,
                             input logic [31:0] word);
      bit illegal, mis, tmo;
      int sz, end_c;
      logic [31:0] e_be, e_wd, e_ld;
      illegal = (rd && wr) || (wr && f3 > 2) || (rd && (f3 == 3 || f3 >= 6));
      sz  = f3 % 4;
      mis = (sz == 1 && (a % 2) != 0) || (sz == 2 && (a % 4) != 0);
      req_valid = 1; mem_read = rd; mem_write = wr; funct3 = f3; addr = a; wdata = wd;
      bus_gnt = 0; bus_rvalid = 0;
      @(negedge clk);
      if (illegal || mis) begin
         check({tag, ".fault"}, 32'(fault), 1);
         check({tag, ".cause"}, 32'(fault_cause), illegal ? 2 : 1);
         check({tag, ".stall"}, 32'(stall), 0);
         check({tag, ".bus_req"}, 32'(bus_req), 0);
         @(posedge clk); #1;
         idle_inputs();
         @(negedge clk);
         check({tag, ".fault_pulse"}, 32'(fault), 0);
         check({tag, ".bus_req_after"}, 32'(bus_req), 0);
         @(posedge clk); #1;
         return;
      end
      check({tag, ".accept_stall"}, 32'(stall), 1);
      check({tag, ".accept_req"}, 32'(bus_req), 0);
      e_be = (sz == 0) ? (32'd1 << (a % 4)) : (sz == 1) ? (32'd3 << (a % 4)) : 32'd15;
      e_wd = (sz == 0) ? (wd % 256) * 32'h01010101 :
             (sz == 1) ? (wd % 65536) * 32'h00010001 : wd;
      e_ld = model_load(f3, a, word);
      tmo   = (g > T - 1);
      end_c = tmo ? T - 1 : (wr ? g : g + r);
      for (int c = 0; c <= end_c + 1; c++) begin
         @(posedge clk); #1;
         bus_gnt    = (c == g) && (c <= end_c);
         bus_rvalid = ((!wr && c == g + r) || (c == 0 && g > 0)) && (c <= end_c);
         bus_rdata  = (c == g + r) ? word : ~word;
         @(negedge clk);
         if (c <= end_c) begin
            check({tag, ".busy_stall"}, 32'(stall), 1);
            check({tag, ".busy_done"}, 32'(done | fault), 0);
            check({tag, ".busy_req"}, 32'(bus_req), (c <= g) ? 1 : 0);
            if (c <= g) begin
               check({tag, ".bus_addr"}, bus_addr, a - (a % 4));
               check({tag, ".bus_be"}, 32'(bus_be), e_be);
               check({tag, ".bus_we"}, 32'(bus_we), 32'(wr));
               if (wr) check({tag, ".bus_wdata"}, bus_wdata, e_wd);
            end
         end else begin
            check({tag, ".done"}, 32'(done), tmo ? 0 : 1);
            check({tag, ".fault_end"}, 32'(fault), tmo ? 1 : 0);
            check({tag, ".cause_end"}, 32'(fault_cause), tmo ? 3 : 0);
            check({tag, ".stall_end"}, 32'(stall), 0);
            check({tag, ".req_end"}, 32'(bus_req), 0);
            check({tag, ".rdata"}, rdata, (wr || tmo) ? 32'h0 : e_ld);
         end
      end
      if (!wr && !tmo) m_rdata = e_ld;
      @(posedge clk); #1;
      idle_inputs();
      @(negedge clk);
      check({tag, ".post_done"}, 32'(done | fault), 0);
      check({tag, ".post_stall"}, 32'(stall), 0);
      check({tag, ".rdata_hold"}, rdata, m_rdata);
      @(posedge clk); #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      idle_inputs();
      bus_rdata = 0;
      rst = 1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset.stall", 32'(stall), 0);
      check("reset.done_fault", 32'(done | fault), 0);
      check("reset.cause", 32'(fault_cause), 0);
      check("reset.rdata", rdata, 0);
      check("reset.bus", {bus_req, bus_we, bus_be, 26'(bus_addr | bus_wdata)}, 0);
      @(posedge clk); #1;
      rst = 0;
      @(posedge clk); #1;

      run_access("sb",  0, 1, 3'd0, 32'h103, 32'hAB, 0, 1, 32'h0);
      run_access("lh",  1, 0, 3'd1, 32'h202, 32'h0, 0, 2, 32'h8001_1234);
      run_access("lhu", 1, 0, 3'd5, 32'h202, 32'h0, 0, 2, 32'h8001_1234);
      run_access("lb",  1, 0, 3'd0, 32'h1,   32'h0, 1, 1, 32'h0000_7F00);
      run_access("lbu", 1, 0, 3'd4, 32'h1,   32'h0, 0, 1, 32'h0000_8000);
      run_access("lw",  1, 0, 3'd2, 32'h8,   32'h0, 2, 3, 32'hDEADBEEF);
      run_access("mis_lw", 1, 0, 3'd2, 32'h6, 32'h0, 0, 1, 32'h0);
      run_access("mis_sh", 0, 1, 3'd1, 32'h5, 32'h0, 0, 1, 32'h0);
      run_access("ill_f3", 1, 0, 3'd3, 32'h0, 32'h0, 0, 1, 32'h0);
      run_access("ill_rw", 1, 1, 3'd2, 32'h0, 32'h0, 0, 1, 32'h0);
      run_access("tmo",    1, 0, 3'd2, 32'h40, 32'h0, 100, 1, 32'h5555_AAAA);
      run_access("gnt_last", 1, 0, 3'd2, 32'h44, 32'h0, T - 1, 1, 32'h1357_9BDF);
      run_access("tmo_st", 0, 1, 3'd2, 32'h48, 32'hCAFE, 100, 1, 32'h0);

      // Reset while a load waits for data; the stale rvalid must be ignored.
      req_valid = 1; mem_read = 1; funct3 = 3'd2; addr = 32'h20;
      @(posedge clk); #1;
      bus_gnt = 1;
      @(posedge clk); #1;
      bus_gnt = 0;
      @(posedge clk); #1;
      rst = 1; req_valid = 0; mem_read = 0;
      @(posedge clk); #1;
      rst = 0; bus_rvalid = 1; bus_rdata = 32'hFFFF_FFFF;
      m_rdata = 0;
      @(negedge clk);
      check("rst_wait.done", 32'(done | fault), 0);
      check("rst_wait.stall", 32'(stall), 0);
      check("rst_wait.rdata", rdata, 0);
      check("rst_wait.req", 32'(bus_req), 0);
      @(posedge clk); #1;
      bus_rvalid = 0;
      @(negedge clk);
      check("rst_wait.late_done", 32'(done), 0);
      check("rst_wait.late_rdata", rdata, 0);
      @(posedge clk); #1;
      run_access("sw", 0, 1, 3'd2, 32'h10, 32'h12345678, 0, 1, 32'h0);

      for (int i = 0; i < 40; i++) begin
         bit rd, wr;
         rd = $urandom_range(1, 0);
         wr = !rd || ($urandom_range(15, 0) == 0);
         run_access("rand", rd, wr, 3'($urandom_range(7, 0)), $urandom_range(32'hFFF, 0),
                    $urandom, $urandom_range(3, 0), $urandom_range(3, 1), $urandom);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
